// File: rtl/activation_unpack.sv
// activation_unpack: converts 1/5/6 sigmoid results into the 1/6/12 neuron format.
// A registered conversion stage feeds a DEPTH-entry FIFO with valid/ready on both sides.
// Optional feature: define ACT_UNPACK_SAT_EN to saturate out-of-range exponents and
// raise a sticky Overflow flag; otherwise the exponent wraps and Overflow is tied low.
module activation_unpack #(
    parameter int DEPTH      = 4,   // power of two, >= 2
    parameter int EXP_OFFSET = 16   // bias 15 -> bias 31; 0..63
) (
    input  logic                     Clock,
    input  logic                     ResetN,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic                     Sign,
    input  logic [4:0]               Exponent,
    input  logic [5:0]               Mantissa,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic                     SignOut,
    output logic [5:0]               ExponentOut,
    output logic [11:0]              MantissaOut,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef ACT_UNPACK_SAT_EN
    localparam int SUM_W = 7;  // keep the carry to detect exponent overflow
`else
    localparam int SUM_W = 6;  // exponent simply wraps
`endif

    typedef struct packed {
        logic        sign;
        logic [5:0]  exp;
        logic [11:0] man;
    } word_t;

    word_t             conv_word;
    word_t             stage_word;
    logic              stage_valid;
    logic [SUM_W-1:0]  sum;
    logic              accept;
    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    word_t             mem [DEPTH];
    word_t             head;
`ifdef ACT_UNPACK_SAT_EN
    logic              conv_sat;
`endif

    // Format conversion of the incoming word (flush-to-zero, re-bias, mantissa widen).
    always_comb begin
        sum            = SUM_W'(Exponent) + SUM_W'(EXP_OFFSET);
        conv_word.sign = Sign;
        conv_word.exp  = sum[5:0];
        conv_word.man  = {Mantissa, 6'b0};
`ifdef ACT_UNPACK_SAT_EN
        conv_sat       = 1'b0;
`endif
        if (Exponent == 5'd0) begin
            conv_word.exp = 6'd0;
            conv_word.man = 12'd0;
        end
`ifdef ACT_UNPACK_SAT_EN
        else if (sum > 7'd63) begin
            conv_word.exp = 6'h3F;
            conv_word.man = 12'hFFF;
            conv_sat      = 1'b1;
        end
`endif
    end

    // Accept only when a FIFO slot is guaranteed for both the stage word and the new one.
    assign InReady = ResetN && (({1'b0, count} + (CNT_W + 1)'(stage_valid)) < (CNT_W + 1)'(DEPTH));
    assign accept  = InValid && InReady;
    assign push    = stage_valid;
    assign pop     = OutValid && OutReady;

    // Conversion stage register; its word always moves into the FIFO on the next edge.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            stage_valid <= 1'b0;
            stage_word  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            stage_valid <= accept;
            if (accept) begin
                stage_word <= conv_word;
            end
        end
    end

    // FIFO storage write.
    // NOTE: the storage array has no reset; empty entries are never visible because the
    // outputs are masked by OutValid, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= stage_word;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef ACT_UNPACK_SAT_EN
    // Sticky saturation flag, set when a saturating word is captured by the stage.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            Overflow <= 1'b0;
        end else if (accept && conv_sat) begin
            Overflow <= 1'b1;
        end
    end
`else
    assign Overflow = 1'b0;
`endif

    // Head word presented combinationally; zeros when the FIFO is empty.
    always_comb begin
        head        = mem[rd_ptr];
        OutValid    = (count != '0);
        SignOut     = 1'b0;
        ExponentOut = 6'd0;
        MantissaOut = 12'd0;
        if (OutValid) begin
            SignOut     = head.sign;
            ExponentOut = head.exp;
            MantissaOut = head.man;
        end
    end

    assign Count = count;

endmodule
